// File: rtl/psum_drain_fifo_pkg.sv
// Shared sizing for the MAC array south-edge drain path (also used by mac_array and the SFU).
package psum_drain_fifo_pkg;

    localparam int unsigned PSUM_BW = 16;
    localparam int unsigned COL     = 8;
    localparam int unsigned DEPTH   = 64;

    // Pointer carries one extra wrap bit above the address bits.
    function automatic int unsigned ptr_w(input int unsigned d);
        return $clog2(d) + 1;
    endfunction

endpackage

// File: rtl/psum_lane_fifo.sv
// Single-lane circular buffer with wrap-bit pointers; head entry is presented combinationally.
module psum_lane_fifo
    import psum_drain_fifo_pkg::*;
#(
    parameter int unsigned width = PSUM_BW,
    parameter int unsigned depth = DEPTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr,
    input  logic [width-1:0] din,
    input  logic             rd,
    output logic [width-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int unsigned PW = ptr_w(depth);
    localparam int unsigned AW = PW - 1;

    logic [width-1:0] mem [depth];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic             do_wr;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

    // A simultaneous pop frees the slot this write needs, so a full lane still accepts it.
    assign do_wr = wr && (!full || rd);
    assign dout  = mem[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_wr) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (rd) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr_q[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/psum_drain_fifo.sv
// Per-column drain buffers that re-align skewed partial sums into whole rows.
// Optional sticky overflow flag o_ovf when PSUM_DRAIN_OVF_EN is defined.
module psum_drain_fifo
    import psum_drain_fifo_pkg::*;
#(
    parameter int unsigned psum_bw = PSUM_BW,
    parameter int unsigned col     = COL,
    parameter int unsigned depth   = DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [psum_bw*col-1:0] in_s,
    input  logic [col-1:0]         in_valid,
    input  logic                   rd,
    output logic [psum_bw*col-1:0] out,
    output logic                   o_valid,
    output logic                   o_full,
    output logic                   o_ready,
`ifdef PSUM_DRAIN_OVF_EN
    output logic                   o_ovf,
`endif
    output logic                   o_out_valid
);

    logic [col-1:0]         empty;
    logic [col-1:0]         full;
    logic [psum_bw*col-1:0] head;
    logic [psum_bw*col-1:0] out_q;
    logic                   out_valid_q;
    logic                   pop;

    // Status depends only on registered pointers inside the lanes.
    assign o_valid = &(~empty);
    assign o_full  = |full;
    assign o_ready = ~o_full;
    assign pop     = rd & o_valid;

    for (genvar c = 0; c < col; c++) begin : g_lane
        psum_lane_fifo #(
            .width (psum_bw),
            .depth (depth)
        ) u_lane (
            .clk   (clk),
            .reset (reset),
            .wr    (in_valid[c]),
            .din   (in_s[psum_bw*c +: psum_bw]),
            .rd    (pop),
            .dout  (head[psum_bw*c +: psum_bw]),
            .empty (empty[c]),
            .full  (full[c])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= pop;
            if (pop) begin
                out_q <= head;
            end
        end
    end

    assign out         = out_q;
    assign o_out_valid = out_valid_q;

`ifdef PSUM_DRAIN_OVF_EN
    logic ovf_q;
    logic drop;

    assign drop = (|(in_valid & full)) & ~pop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf_q <= 1'b0;
        end else if (drop) begin
            ovf_q <= 1'b1;
        end
    end

    assign o_ovf = ovf_q;
`endif

endmodule
